// File: rtl/uart_tx_arbiter.sv
// Two-port UART TX arbiter with built-in 8N1 serializer.
// Round-robin per message; the grant is held until a byte flagged 'last' has been sent.
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 234,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic       sysclk,
  input  logic       sys_rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic [1:0] grant
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST_C = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [15:0] TO_LAST_C = 16'(LOCK_TIMEOUT - 1);
  localparam logic TO_EN_C = (LOCK_TIMEOUT != 32'sd0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t            state_r;
  logic              ptr_r;
  logic              locked_r;
  logic              owner_r;
  logic [7:0]        shreg_r;
  logic [2:0]        bit_idx_r;
  logic [BAUD_W-1:0] baud_r;
  logic [15:0]       to_cnt_r;
  logic              tx_r;
  logic              busy_r;
  logic [1:0]        grant_r;

  logic [1:0] valid_s;
  logic       cand_s;
  logic       cand_ok_s;
  logic       sel_s;
  logic       open_s;
  logic       accept_s;
  logic       owner_valid_s;
  logic [7:0] sel_data_s;
  logic       sel_last_s;

  assign valid_s = {req1_valid, req0_valid};
  assign tx      = tx_r;
  assign busy    = busy_r;
  assign grant   = grant_r;

  // Arbitration: pick the candidate port and drive the ready handshakes.
  always_comb begin
    cand_s     = ptr_r;
    cand_ok_s  = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (valid_s[ptr_r]) begin
      cand_s    = ptr_r;
      cand_ok_s = 1'b1;
    end else if (valid_s[~ptr_r]) begin
      cand_s    = ~ptr_r;
      cand_ok_s = 1'b1;
    end else begin
      cand_s    = ptr_r;
      cand_ok_s = 1'b0;
    end
    // A locked owner keeps the line even while its valid is low.
    sel_s  = locked_r ? owner_r : cand_s;
    open_s = (state_r == ST_IDLE) && !sys_rst;
    if (open_s && (locked_r || cand_ok_s)) begin
      req0_ready = ~sel_s;
      req1_ready = sel_s;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
    accept_s      = (req0_ready && req0_valid) || (req1_ready && req1_valid);
    owner_valid_s = owner_r ? req1_valid : req0_valid;
    sel_data_s    = sel_s ? req1_data : req0_data;
    sel_last_s    = sel_s ? req1_last : req0_last;
  end

  // Serializer FSM, lock/timeout bookkeeping and registered outputs.
  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r   <= ST_IDLE;
      ptr_r     <= 1'b0;
      locked_r  <= 1'b0;
      owner_r   <= 1'b0;
      shreg_r   <= 8'h00;
      bit_idx_r <= 3'd0;
      baud_r    <= '0;
      to_cnt_r  <= 16'd0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      grant_r   <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          baud_r    <= '0;
          bit_idx_r <= 3'd0;
          if (accept_s) begin
            owner_r  <= sel_s;
            grant_r  <= sel_s ? 2'b10 : 2'b01;
            shreg_r  <= sel_data_s;
            tx_r     <= 1'b0;
            busy_r   <= 1'b1;
            state_r  <= ST_START;
            to_cnt_r <= 16'd0;
            if (sel_last_s) begin
              locked_r <= 1'b0;
              ptr_r    <= ~sel_s;
            end else begin
              locked_r <= 1'b1;
            end
          end else if (locked_r && !owner_valid_s) begin
            if (TO_EN_C && (to_cnt_r == TO_LAST_C)) begin
              locked_r <= 1'b0;
              grant_r  <= 2'b00;
              ptr_r    <= ~owner_r;
              to_cnt_r <= 16'd0;
            end else begin
              to_cnt_r <= to_cnt_r + 16'd1;
            end
          end else if (!locked_r) begin
            to_cnt_r <= 16'd0;
          end else begin
            to_cnt_r <= to_cnt_r;
          end
        end
        ST_START: begin
          if (baud_r == BAUD_LAST_C) begin
            baud_r  <= '0;
            tx_r    <= shreg_r[0];
            state_r <= ST_DATA;
          end else begin
            baud_r <= baud_r + BAUD_W'(1'b1);
          end
        end
        ST_DATA: begin
          if (baud_r == BAUD_LAST_C) begin
            baud_r <= '0;
            if (bit_idx_r == 3'd7) begin
              tx_r    <= 1'b1;
              state_r <= ST_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= shreg_r[1];
              shreg_r   <= {1'b0, shreg_r[7:1]};
            end
          end else begin
            baud_r <= baud_r + BAUD_W'(1'b1);
          end
        end
        ST_STOP: begin
          if (baud_r == BAUD_LAST_C) begin
            baud_r  <= '0;
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            if (!locked_r) begin
              grant_r <= 2'b00;
            end else begin
              grant_r <= grant_r;
            end
          end else begin
            baud_r <= baud_r + BAUD_W'(1'b1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed and random message streams, with the wire
// decoded and compared against a message-level arbitration model.
module tb_uart_tx_arbiter;

  localparam int C     = 4;
  localparam int TO_A  = 20;
  localparam int FRAME = 10 * C;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    logic [7:0] data;
    logic       port;
    int         gap;
  } exp_t;

  logic       sysclk = 1'b0;
  logic       sys_rst;
  logic       req0_valid, req0_last, req0_ready;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic       tx, busy;
  logic [1:0] grant;

  logic       b_req0_valid, b_req0_last, b_req0_ready;
  logic       b_req1_valid, b_req1_last, b_req1_ready;
  logic [7:0] b_req0_data, b_req1_data;
  logic       b_tx, b_busy;
  logic [1:0] b_grant;

  beat_t      q0[$];
  beat_t      q1[$];
  exp_t       exp_q[$];
  logic       exp_ptr;
  logic       tx_w[$];
  logic       busy_w[$];
  logic [1:0] gr_w[$];
  logic [1:0] rdy_w[$];
  int         checks = 0;
  int         errors = 0;

  always #5 sysclk = ~sysclk;

  uart_tx_arbiter #(.CLKS_PER_BIT(C), .LOCK_TIMEOUT(TO_A)) dut_a (
    .sysclk(sysclk), .sys_rst(sys_rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx(tx), .busy(busy), .grant(grant)
  );

  uart_tx_arbiter #(.CLKS_PER_BIT(C), .LOCK_TIMEOUT(0)) dut_b (
    .sysclk(sysclk), .sys_rst(sys_rst),
    .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_last(b_req0_last), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_last(b_req1_last), .req1_ready(b_req1_ready),
    .tx(b_tx), .busy(b_busy), .grant(b_grant)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    sys_rst = 1'b1;
    @(negedge sysclk);
    @(posedge sysclk);
    #1 sys_rst = 1'b0;
    exp_ptr = 1'b0;
  endtask

  // Message-level model: whole messages alternate, starting at the priority port;
  // an owner that runs dry mid-message stalls for the timeout before the other port goes.
  task automatic build_expect();
    beat_t m0[$];
    beat_t m1[$];
    beat_t b;
    exp_t  e;
    logic  port;
    int    extra;
    bit    first;
    m0 = q0;
    m1 = q1;
    exp_q.delete();
    first = 1'b1;
    extra = 0;
    while (m0.size() + m1.size() > 0) begin
      if (exp_ptr == 1'b0) port = (m0.size() > 0) ? 1'b0 : 1'b1;
      else port = (m1.size() > 0) ? 1'b1 : 1'b0;
      do begin
        if (port == 1'b0) b = m0.pop_front();
        else b = m1.pop_front();
        e.data = b.data;
        e.port = port;
        e.gap  = first ? 0 : FRAME + 1 + extra;
        exp_q.push_back(e);
        first = 1'b0;
        extra = 0;
      end while (!b.last && (((port == 1'b0) ? m0.size() : m1.size()) > 0));
      if (!b.last) extra = TO_A;
      exp_ptr = ~port;
    end
  endtask

  task automatic drive_inputs();
    req0_valid = (q0.size() > 0);
    req0_data  = (q0.size() > 0) ? q0[0].data : 8'h00;
    req0_last  = (q0.size() > 0) ? q0[0].last : 1'b0;
    req1_valid = (q1.size() > 0);
    req1_data  = (q1.size() > 0) ? q1[0].data : 8'h00;
    req1_last  = (q1.size() > 0) ? q1[0].last : 1'b0;
  endtask

  task automatic check_stream(input string name);
    int         s, n, prev, bad;
    logic [9:0] obs, expf;
    n = 0;
    prev = 0;
    if (exp_q.size() > 0) chk({name, " first_ready"}, 32'(rdy_w[0]), 32'(onehot(exp_q[0].port)));
    s = 1;
    while (s < tx_w.size()) begin
      if (tx_w[s] == 1'b0 && tx_w[s-1] == 1'b1) begin
        if (n >= exp_q.size()) begin
          chk({name, " extra_frame"}, 32'(n + 1), 32'(exp_q.size()));
          break;
        end
        if (s + FRAME > tx_w.size()) begin
          chk({name, " frame_truncated"}, 32'(tx_w.size() - s), 32'(FRAME));
          break;
        end
        expf = {1'b1, exp_q[n].data, 1'b0};
        bad = 0;
        for (int j = 0; j < 10; j++) obs[j] = tx_w[s + j*C + C/2];
        for (int k = 0; k < FRAME; k++) if (tx_w[s + k] !== expf[k / C]) bad++;
        chk({name, " frame"}, 32'(obs), 32'(expf));
        chk({name, " wave_bad_samples"}, 32'(bad), 32'd0);
        chk({name, " grant"}, 32'(gr_w[s + C/2]), 32'(onehot(exp_q[n].port)));
        chk({name, " busy"}, 32'(busy_w[s + 5*C]), 32'd1);
        if (exp_q[n].gap != 0) chk({name, " gap"}, 32'(s - prev), 32'(exp_q[n].gap));
        prev = s;
        n++;
        s += FRAME;
      end else begin
        s++;
      end
    end
    chk({name, " frame_count"}, 32'(n), 32'(exp_q.size()));
    chk({name, " end_grant"}, 32'(gr_w[gr_w.size()-1]), 32'd0);
    chk({name, " end_busy"}, 32'(busy_w[busy_w.size()-1]), 32'd0);
  endtask

  task automatic run_stream(input string name);
    int   cyc, tail;
    logic h0, h1;
    tx_w.delete();
    busy_w.delete();
    gr_w.delete();
    rdy_w.delete();
    build_expect();
    drive_inputs();
    cyc = 0;
    tail = 0;
    while (tail < FRAME + 4 && cyc < 4000) begin
      @(negedge sysclk);
      tx_w.push_back(tx);
      busy_w.push_back(busy);
      gr_w.push_back(grant);
      rdy_w.push_back({req1_ready, req0_ready});
      h0 = req0_valid & req0_ready;
      h1 = req1_valid & req1_ready;
      @(posedge sysclk);
      #1;
      if (h0) q0.delete(0);
      if (h1) q1.delete(0);
      drive_inputs();
      cyc++;
      if (q0.size() == 0 && q1.size() == 0) tail++;
    end
    chk({name, " stream_done"}, 32'(cyc < 4000), 32'd1);
    check_stream(name);
  endtask

  function automatic beat_t mk(input logic [7:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    return b;
  endfunction

  initial begin
    bit found;
    int cnt;
    b_req0_valid = 1'b0; b_req0_data = 8'h00; b_req0_last = 1'b0;
    b_req1_valid = 1'b0; b_req1_data = 8'h00; b_req1_last = 1'b0;
    req0_data = 8'h00; req0_last = 1'b0; req1_data = 8'h00; req1_last = 1'b1;

    // Reset state, with both requesters asserting valid during reset.
    sys_rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge sysclk);
    @(negedge sysclk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    do_reset();

    // Single byte 0x55 on port 0.
    q0.push_back(mk(8'h55, 1'b1));
    run_stream("single");

    // Priority now on port 1: 3-byte port-1 message blocks port 0.
    q1.push_back(mk(8'h11, 1'b0));
    q1.push_back(mk(8'h22, 1'b0));
    q1.push_back(mk(8'h33, 1'b1));
    q0.push_back(mk(8'h44, 1'b1));
    run_stream("locked_msg");

    // Both valid straight after reset.
    do_reset();
    q0.push_back(mk(8'hA0, 1'b1));
    q1.push_back(mk(8'h0B, 1'b1));
    run_stream("both_valid");

    // Stalled owner released by the timeout.
    q0.push_back(mk(8'h5A, 1'b0));
    q1.push_back(mk(8'hE7, 1'b1));
    run_stream("timeout");

    // Reset during data bit 3 discards the frame and the lock.
    req0_valid = 1'b1; req0_data = 8'hC3; req0_last = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge sysclk);
      if (req0_ready) found = 1'b1;
    end
    chk("mid_accept", 32'(found), 32'd1);
    @(posedge sysclk);
    #1 req0_valid = 1'b0;
    repeat (17) @(posedge sysclk);
    #3;
    chk("mid_pre_tx_bit3", 32'(tx), 32'd0);
    chk("mid_pre_grant", 32'(grant), 32'd1);
    sys_rst = 1'b1;
    #1;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    req0_valid = 1'b1;
    @(negedge sysclk);
    chk("mid_rst_ready", 32'(req0_ready), 32'd0);
    @(posedge sysclk);
    #1;
    req0_valid = 1'b0;
    sys_rst = 1'b0;
    exp_ptr = 1'b0;
    q1.push_back(mk(8'h3C, 1'b1));
    run_stream("after_mid_reset");

    // Random messages on both ports.
    for (int r = 0; r < 3; r++) begin
      int nm, len;
      for (int p = 0; p < 2; p++) begin
        nm = $urandom_range(1, 3);
        for (int m = 0; m < nm; m++) begin
          len = $urandom_range(1, 3);
          for (int k = 0; k < len; k++) begin
            if (p == 0) q0.push_back(mk(8'($urandom), (k == len - 1)));
            else q1.push_back(mk(8'($urandom), (k == len - 1)));
          end
        end
      end
      run_stream($sformatf("random%0d", r));
    end

    // Timeout disabled: a stalled owner holds the lock indefinitely.
    b_req0_valid = 1'b1; b_req0_data = 8'h81; b_req0_last = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge sysclk);
      if (b_req0_ready) found = 1'b1;
    end
    chk("nto_accept", 32'(found), 32'd1);
    @(posedge sysclk);
    #1;
    b_req0_valid = 1'b0;
    b_req1_valid = 1'b1; b_req1_data = 8'h7E; b_req1_last = 1'b1;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge sysclk);
      if (b_req1_ready) cnt++;
    end
    chk("nto_other_ready_cycles", 32'(cnt), 32'd0);
    chk("nto_grant", 32'(b_grant), 32'd1);
    chk("nto_busy", 32'(b_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the board's single UART TX pin between two byte-level requesters: the CPU console path (port 0) and the FPGA-side debug/status monitor (port 1). It contains its own 8N1 serializer, arbitrates round-robin per message, and holds the grant until a whole message (terminated by `last`) has been sent, so console and monitor lines never interleave. It sits in the FPGA top level between the requesters and the `uartTx` pin.

## Interface
- `CLKS_PER_BIT`, 234, sysclk cycles per UART bit (27 MHz / 115200); legal ≥ 2.
- `LOCK_TIMEOUT`, 65535, idle sysclk cycles a locked owner may stall before the lock is dropped; 0 disables the timeout; counter is 16 bits.
- `sysclk`  in  1  system clock; all logic on the rising edge.
- `sys_rst`  in  1  reset, asynchronous, active-high.
- `req0_valid`  in  1  port 0 has a byte.
- `req0_data`  in  8  port 0 byte.
- `req0_last`  in  1  byte ends port 0's message.
- `req0_ready`  out  1  port 0 byte accepted when `valid && ready`.
- `req1_valid`, `req1_data[7:0]`, `req1_last`, `req1_ready`: same as port 0, for port 1.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  a frame is being shifted (state ≠ IDLE).
- `grant`  out  2  one-hot owner of the current or locked message; 00 when free.

## Operation
- States: IDLE, START, DATA, STOP. Registers: `ptr` (round-robin priority, 0/1), `locked`, `owner`, shift register, bit index (0–7), baud counter, timeout counter.
- IDLE, unlocked: candidate = `ptr` if its valid is high, else the other port if its valid is high. Only the candidate's ready is high. `ready` is combinational on state/lock/ptr/valid inputs.
- IDLE, locked: only `owner`'s ready is high; the other port is ignored regardless of its valid.
- On acceptance: latch data, go to START, `owner` = accepted port, `grant` = its one-hot. If `last` = 0, set `locked`. If `last` = 1, clear `locked` and set `ptr` = other port.
- START: `tx` = 0 for CLKS_PER_BIT cycles. DATA: bits 0..7, LSB first, each CLKS_PER_BIT cycles. STOP: `tx` = 1 for CLKS_PER_BIT cycles, then IDLE.
- `grant` clears on return to IDLE when unlocked. It stays at the owner while locked.
- Timeout: in IDLE with `locked` and owner valid low, the counter increments each cycle. It clears on any acceptance or when leaving the locked state. On reaching LOCK_TIMEOUT (if nonzero): clear `locked`, clear `grant`, set `ptr` = other port.
- Simultaneous valid on both ports while unlocked: `ptr` wins. After reset `ptr` = 0.
- Inputs are sampled only at acceptance. Changes on `data`/`last` mid-frame have no effect.

## Timing
- Reset values (async, immediate): `tx` = 1, `busy` = 0, `grant` = 00, `locked` = 0, `ptr` = 0, state = IDLE. Ready outputs follow the IDLE rules once reset is released.
- Acceptance edge T: `tx` falls at T+1. The stop bit ends at T+10·CLKS_PER_BIT. `busy` is high from T+1 through T+10·CLKS_PER_BIT.
- Earliest next acceptance is the first cycle of IDLE, T+10·CLKS_PER_BIT+1. That gives 10·CLKS_PER_BIT+1 cycles per back-to-back byte, with no extra gap.
- Reset asserted mid-frame: `tx` goes high immediately, and the partial frame and lock are discarded. No ready pulse occurs while reset is asserted.
- Timeout release happens on the edge where the count equals LOCK_TIMEOUT. Acceptance on that same edge is not possible, because ready is from the owner only and owner valid is low.

## Test plan
- Single byte, CLKS_PER_BIT=4: req0 sends 0x55 with last=1. Required: `tx` = 0,1,0,1,0,1,0,1,0,1 per 4-cycle bit; `grant` 01 during the frame, 00 after; `ptr` = 1.
- Both valid after reset, each with last=1, bytes 0xA0/0x0B: port 0 is sent first, then port 1 on the next IDLE cycle. Frames are 41 cycles apart at CLKS_PER_BIT=4.
- Port 1 message of 3 bytes (last on the 3rd), port 0 valid throughout: port 0 ready stays 0 until all 3 port-1 frames finish. Port 0 is then granted and `grant` goes 10→01.
- LOCK_TIMEOUT=20: port 0 sends one byte with last=0 and then drops valid, while port 1 is valid. Port 1 ready is 0 for 20 idle cycles, then the lock releases and port 1 is accepted on the next cycle.
- Reset asserted mid-DATA (bit 3): `tx` goes to 1 asynchronously, and `busy`/`grant` go to 0. After release, a new byte transmits correctly from its start bit.
- LOCK_TIMEOUT=0 with a stalled locked owner for 1000 cycles: the lock never drops and the other port is never ready.
